pipe_control: RTL and testbench
===============================

Name: pipe_control

Overview:
- Pipelined successor to the single-cycle control decoder for the 4-bit-opcode ARM-lite core (ADDI, ADDS, BLT, B, CBZ, LDUR, LSL, LSR, MUL, STUR, SUBS).
- Decodes in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and holds the front end while a multi-cycle MUL occupies EX.
- Handles branch flushes and flags illegal opcodes.

Parameters:
REGW, 5, register index width; the all-ones index (X31/XZR) never causes a hazard.
MUL_LAT, 3, cycles a MUL occupies EX; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
id_valid  input  1  ID holds a real instruction.
opcode  input  4  ID opcode; encodings ADDI=1, ADDS=2, BLT=3, B=4, CBZ=5, LDUR=6, LSL=7, LSR=8, MUL=9, STUR=10, SUBS=11; all others are illegal.
id_rd  input  REGW  Rd/Rt field.
id_rn  input  REGW  Rn field.
id_rm  input  REGW  Rm field.
ext_flush  input  1  branch taken in EX; kill the ID instruction.
id_Reg2Loc  output  1  combinational; 0 for STUR/CBZ, else 1.
stall_id  output  1  combinational; hold PC and the IF/ID register.
ex_valid  output  1  EX holds a real instruction.
ex_ALUSrc  output  2  {ADDI, LDUR|STUR}.
ex_ALUOp  output  3  SUBS=3, CBZ=0, else 2.
ex_rd  output  REGW  EX destination register.
mem_valid  output  1  MEM holds a real instruction.
mem_MemWrite  output  1  STUR.
mem_MemRead  output  1  LDUR.
wb_RegWrite  output  1  0 for B/BLT/CBZ/STUR; gated by valid.
wb_MemToReg  output  2  LDUR=1, MUL=2, LSL/LSR=3, else 0.
wb_rd  output  REGW  writeback register.
illegal  output  1  registered one-cycle pulse.

Behaviour:
- Reset (asynchronous): all valids, control outputs, rd fields, illegal and the MUL counter go to 0. stall_id is 0 from the first cycle after reset.
- Decode: combinational from opcode and id_valid. An illegal opcode with id_valid=1 loads a bubble into EX and pulses illegal on the next cycle. Every control bit in every stage is ANDed with that stage's valid.
- Latency: ID→EX, EX→MEM and MEM→WB are one cycle each. A non-MUL instruction reaches the wb_* outputs 3 cycles after it is accepted.
- Source-register usage:
  - Rn is read by ADDI, ADDS, LDUR, LSL, LSR, MUL, STUR, SUBS.
  - The second source is read by ADDS, MUL, SUBS (taken from id_rm) and by STUR, CBZ (taken from id_rd, per Reg2Loc).
- Load-use hazard: asserted when ex_valid, EX is LDUR, ex_rd is not all-ones, and ex_rd equals a source register read in ID. Response: stall_id=1 and a bubble enters EX for exactly 1 cycle.
- MUL:
  - On entering EX, the counter loads MUL_LAT-1.
  - While the counter is nonzero: the EX register holds, bubbles enter MEM, stall_id=1, the ID instruction waits, and the counter decrements each cycle.
  - The MUL advances to MEM on the cycle the counter is 0.
  - MUL_LAT=1 behaves as a plain single-cycle instruction.
- Priority, highest first: reset, MUL busy (ext_flush ignored), ext_flush (bubble into EX, stall_id=0 that cycle), load-use stall, normal advance.
- A stalled or flushed ID instruction never produces an illegal pulse.
- Reset during MUL busy: the counter clears and stall_id is 0 the cycle after reset deasserts.
- No forwarding logic is in this block.

Test Plan:
1. Stream ADDI, STUR, LDUR, B → wb_RegWrite pattern 1,0,1,0 on cycles 3-6 after the first accept; mem_MemWrite=1 only for STUR; wb_MemToReg=1 for LDUR.
2. LDUR X3 then ADDS X5,X3,X4 → stall_id=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADDS proceeds. Repeat with LDUR X31: no stall.
3. LDUR X2 then STUR X2 (Rt=X2, base X7) → stall via the second-source path. Same pattern with CBZ X2 → stall.
4. MUL_LAT=3: MUL followed by ADDI → stall_id high 2 cycles, mem_valid=0 for 2 cycles, MUL at WB with wb_MemToReg=2; ext_flush asserted mid-busy has no effect.
5. ext_flush with ADDI in ID → ex_valid=0 next cycle, no RegWrite for ADDI at WB. Opcode 13 with id_valid=1 → illegal pulses 1 cycle, bubble inserted.
6. Assert reset 1 cycle into a MUL → all outputs 0 immediately; after release stall_id=0 and the pipeline is empty.

Source files
------------

// File: rtl/pipe_control.sv
// pipe_control: control path of the pipelined 4-bit-opcode ARM-lite core.
//
// Decodes the instruction in ID and carries its control bundle through
// the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, holds
// the front end while a multi-cycle MUL occupies EX, kills the ID
// instruction on a taken branch (ext_flush) and pulses illegal for
// undefined opcodes. No forwarding is done here.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   id_valid, opcode        ID instruction qualifier and opcode
//   id_rd, id_rn, id_rm     ID register fields
//   ext_flush               branch taken in EX, kill the ID instruction
//   id_Reg2Loc              combinational second-source select (0: Rd/Rt)
//   stall_id                combinational hold for PC and IF/ID
//   ex_valid, ex_ALUSrc, ex_ALUOp, ex_rd            EX stage bundle
//   mem_valid, mem_MemWrite, mem_MemRead            MEM stage bundle
//   wb_RegWrite, wb_MemToReg, wb_rd                 WB stage bundle
//   illegal                 one-cycle pulse for an accepted illegal opcode
//
// Handshake: id_valid qualifies the ID fields. The ID instruction is
// consumed on a rising edge where stall_id=0; while stall_id=1 the same
// instruction must be presented again. ext_flush discards it instead.
// Every registered control bit is stored already ANDed with its stage's
// valid, so a bubble shows all-zero controls and rd.
module pipe_control #(
  parameter int REGW    = 5,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [3:0]      opcode,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rn,
  input  logic [REGW-1:0] id_rm,
  input  logic            ext_flush,
  output logic            id_Reg2Loc,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [1:0]      ex_ALUSrc,
  output logic [2:0]      ex_ALUOp,
  output logic [REGW-1:0] ex_rd,
  output logic            mem_valid,
  output logic            mem_MemWrite,
  output logic            mem_MemRead,
  output logic            wb_RegWrite,
  output logic [1:0]      wb_MemToReg,
  output logic [REGW-1:0] wb_rd,
  output logic            illegal
);

  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADDS = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_CBZ  = 4'd5;
  localparam logic [3:0] OP_LDUR = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_STUR = 4'd10;
  localparam logic [3:0] OP_SUBS = 4'd11;

  localparam logic [REGW-1:0] XZR      = '1;
  localparam logic [3:0]      MUL_LOAD = 4'(MUL_LAT - 1);

  // ID decode
  logic            d_legal;
  logic            d_rn_used;
  logic            d_src2_used;
  logic [1:0]      d_alusrc;
  logic [2:0]      d_aluop;
  logic            d_memwrite;
  logic            d_memread;
  logic            d_regwrite;
  logic [1:0]      d_memtoreg;
  logic            d_is_mul;
  logic [REGW-1:0] id_src2;

  // Stage state not visible on the ports
  logic            ex_memwrite;
  logic            ex_memread;
  logic            ex_regwrite;
  logic [1:0]      ex_memtoreg;
  logic            mem_regwrite;
  logic [1:0]      mem_memtoreg;
  logic [REGW-1:0] mem_rd;
  logic [3:0]      mul_cnt;

  logic mul_busy;
  logic load_use;
  logic id_take;
  logic ex_load;

  always_comb begin
    d_legal     = 1'b1;
    d_rn_used   = 1'b0;
    d_src2_used = 1'b0;
    d_alusrc    = 2'b00;
    d_aluop     = 3'd2;
    d_memwrite  = 1'b0;
    d_memread   = 1'b0;
    d_regwrite  = 1'b0;
    d_memtoreg  = 2'd0;
    d_is_mul    = 1'b0;
    id_Reg2Loc  = 1'b1;
    case (opcode)
      OP_ADDI: begin
        d_rn_used  = 1'b1;
        d_alusrc   = 2'b10;
        d_regwrite = 1'b1;
      end
      OP_ADDS: begin
        d_rn_used   = 1'b1;
        d_src2_used = 1'b1;
        d_regwrite  = 1'b1;
      end
      OP_BLT, OP_B: begin
      end
      OP_CBZ: begin
        d_src2_used = 1'b1;
        d_aluop     = 3'd0;
        id_Reg2Loc  = 1'b0;
      end
      OP_LDUR: begin
        d_rn_used  = 1'b1;
        d_alusrc   = 2'b01;
        d_memread  = 1'b1;
        d_regwrite = 1'b1;
        d_memtoreg = 2'd1;
      end
      OP_LSL, OP_LSR: begin
        d_rn_used  = 1'b1;
        d_regwrite = 1'b1;
        d_memtoreg = 2'd3;
      end
      OP_MUL: begin
        d_rn_used   = 1'b1;
        d_src2_used = 1'b1;
        d_regwrite  = 1'b1;
        d_memtoreg  = 2'd2;
        d_is_mul    = 1'b1;
      end
      OP_STUR: begin
        d_rn_used   = 1'b1;
        d_src2_used = 1'b1;
        d_alusrc    = 2'b01;
        d_memwrite  = 1'b1;
        id_Reg2Loc  = 1'b0;
      end
      OP_SUBS: begin
        d_rn_used   = 1'b1;
        d_src2_used = 1'b1;
        d_aluop     = 3'd3;
        d_regwrite  = 1'b1;
      end
      default: begin
        d_legal = 1'b0;
        d_aluop = 3'd0;
      end
    endcase
  end

  // STUR/CBZ read their second operand through the Rd/Rt field.
  assign id_src2 = id_Reg2Loc ? id_rm : id_rd;

  // ex_memread marks an LDUR in EX; its result is not ready for the
  // instruction right behind it. XZR is never a real dependency.
  assign load_use = ex_valid && ex_memread && (ex_rd != XZR) && id_valid &&
                    ((d_rn_used && (id_rn == ex_rd)) ||
                     (d_src2_used && (id_src2 == ex_rd)));

  assign mul_busy = (mul_cnt != 4'd0);

  // A busy MUL overrides a flush; a flush drops the ID instruction so it
  // cannot also stall.
  assign stall_id = mul_busy || (load_use && !ext_flush);

  assign id_take = id_valid && !ext_flush && !load_use;
  assign ex_load = id_take && d_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_ALUSrc    <= 2'b00;
      ex_ALUOp     <= 3'd0;
      ex_rd        <= '0;
      ex_memwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 2'd0;
      mem_valid    <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_MemRead  <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 2'd0;
      mem_rd       <= '0;
      wb_RegWrite  <= 1'b0;
      wb_MemToReg  <= 2'd0;
      wb_rd        <= '0;
      illegal      <= 1'b0;
      mul_cnt      <= 4'd0;
    end else begin
      // MEM/WB always follows MEM.
      wb_RegWrite <= mem_regwrite;
      wb_MemToReg <= mem_memtoreg;
      wb_rd       <= mem_rd;

      if (mul_busy) begin
        // EX holds the MUL; MEM receives bubbles until the count drains.
        mem_valid    <= 1'b0;
        mem_MemWrite <= 1'b0;
        mem_MemRead  <= 1'b0;
        mem_regwrite <= 1'b0;
        mem_memtoreg <= 2'd0;
        mem_rd       <= '0;
        mul_cnt      <= mul_cnt - 4'd1;
        illegal      <= 1'b0;
      end else begin
        mem_valid    <= ex_valid;
        mem_MemWrite <= ex_memwrite;
        mem_MemRead  <= ex_memread;
        mem_regwrite <= ex_regwrite;
        mem_memtoreg <= ex_memtoreg;
        mem_rd       <= ex_rd;

        if (ex_load) begin
          ex_valid    <= 1'b1;
          ex_ALUSrc   <= d_alusrc;
          ex_ALUOp    <= d_aluop;
          ex_rd       <= id_rd;
          ex_memwrite <= d_memwrite;
          ex_memread  <= d_memread;
          ex_regwrite <= d_regwrite;
          ex_memtoreg <= d_memtoreg;
        end else begin
          ex_valid    <= 1'b0;
          ex_ALUSrc   <= 2'b00;
          ex_ALUOp    <= 3'd0;
          ex_rd       <= '0;
          ex_memwrite <= 1'b0;
          ex_memread  <= 1'b0;
          ex_regwrite <= 1'b0;
          ex_memtoreg <= 2'd0;
        end

        // MUL_LAT=1 loads zero and the MUL flows like any other op.
        mul_cnt <= (ex_load && d_is_mul) ? MUL_LOAD : 4'd0;
        illegal <= id_take && !d_legal;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
module tb_pipe_control;

  localparam int REGW    = 5;
  localparam int MUL_LAT = 3;

  localparam logic [3:0] ADDI = 4'd1;
  localparam logic [3:0] ADDS = 4'd2;
  localparam logic [3:0] BLT  = 4'd3;
  localparam logic [3:0] B    = 4'd4;
  localparam logic [3:0] CBZ  = 4'd5;
  localparam logic [3:0] LDUR = 4'd6;
  localparam logic [3:0] LSL  = 4'd7;
  localparam logic [3:0] LSR  = 4'd8;
  localparam logic [3:0] MUL  = 4'd9;
  localparam logic [3:0] STUR = 4'd10;
  localparam logic [3:0] SUBS = 4'd11;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            id_valid = 1'b0;
  logic [3:0]      opcode = 4'd0;
  logic [REGW-1:0] id_rd = '0;
  logic [REGW-1:0] id_rn = '0;
  logic [REGW-1:0] id_rm = '0;
  logic            ext_flush = 1'b0;
  logic            id_Reg2Loc;
  logic            stall_id;
  logic            ex_valid;
  logic [1:0]      ex_ALUSrc;
  logic [2:0]      ex_ALUOp;
  logic [REGW-1:0] ex_rd;
  logic            mem_valid;
  logic            mem_MemWrite;
  logic            mem_MemRead;
  logic            wb_RegWrite;
  logic [1:0]      wb_MemToReg;
  logic [REGW-1:0] wb_rd;
  logic            illegal;

  always #5 clk = ~clk;

  pipe_control #(.REGW(REGW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .ext_flush(ext_flush),
    .id_Reg2Loc(id_Reg2Loc), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .wb_RegWrite(wb_RegWrite),
    .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd), .illegal(illegal)
  );

  // ---------------- reference model ----------------
  // Each pipeline slot is just "which instruction sits here"; outputs are
  // derived from the opcode tables when checked.
  typedef struct packed {
    logic            v;
    logic [3:0]      op;
    logic [REGW-1:0] rd;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  int    m_mul_left;
  logic  m_illegal;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic s_stall;
  logic s_r2l;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd11);
  endfunction

  function automatic logic reads_rn(input logic [3:0] op);
    return op inside {ADDI, ADDS, LDUR, LSL, LSR, MUL, STUR, SUBS};
  endfunction

  function automatic logic reads_second(input logic [3:0] op);
    return op inside {ADDS, MUL, SUBS, STUR, CBZ};
  endfunction

  function automatic logic model_hazard();
    logic [REGW-1:0] second;
    second = (opcode == STUR || opcode == CBZ) ? id_rd : id_rm;
    if (!(m_ex.v && m_ex.op == LDUR && m_ex.rd != 5'd31 && id_valid)) return 1'b0;
    return (reads_rn(opcode) && id_rn == m_ex.rd) ||
           (reads_second(opcode) && second == m_ex.rd);
  endfunction

  function automatic logic [1:0] f_alusrc(input slot_t s);
    if (!s.v) return 2'b00;
    return {s.op == ADDI, (s.op == LDUR) || (s.op == STUR)};
  endfunction

  function automatic logic [2:0] f_aluop(input slot_t s);
    if (!s.v) return 3'd0;
    if (s.op == SUBS) return 3'd3;
    if (s.op == CBZ) return 3'd0;
    return 3'd2;
  endfunction

  function automatic logic f_regwrite(input slot_t s);
    return s.v && !(s.op inside {B, BLT, CBZ, STUR});
  endfunction

  function automatic logic [1:0] f_memtoreg(input slot_t s);
    if (!s.v) return 2'd0;
    if (s.op == LDUR) return 2'd1;
    if (s.op == MUL) return 2'd2;
    if (s.op == LSL || s.op == LSR) return 2'd3;
    return 2'd0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic exp_stall;
    exp_stall = (m_mul_left > 0) || (!ext_flush && model_hazard());
    check("stall_id", stall_id, exp_stall);
    if (id_valid) check("id_Reg2Loc", id_Reg2Loc, !(opcode == STUR || opcode == CBZ));
    check("ex_valid", ex_valid, m_ex.v);
    check("ex_ALUSrc", ex_ALUSrc, f_alusrc(m_ex));
    check("ex_ALUOp", ex_ALUOp, f_aluop(m_ex));
    if (m_ex.v) check("ex_rd", ex_rd, m_ex.rd);
    check("mem_valid", mem_valid, m_mem.v);
    check("mem_MemWrite", mem_MemWrite, m_mem.v && m_mem.op == STUR);
    check("mem_MemRead", mem_MemRead, m_mem.v && m_mem.op == LDUR);
    check("wb_RegWrite", wb_RegWrite, f_regwrite(m_wb));
    check("wb_MemToReg", wb_MemToReg, f_memtoreg(m_wb));
    if (m_wb.v) check("wb_rd", wb_rd, m_wb.rd);
    check("illegal", illegal, m_illegal);
  endtask

  task automatic model_advance();
    logic hz;
    logic acc;
    hz = model_hazard();
    m_wb = m_mem;
    if (m_mul_left > 0) begin
      m_mem = '0;
      m_mul_left--;
      m_illegal = 1'b0;
    end else begin
      m_mem = m_ex;
      acc = id_valid && !ext_flush && !hz;
      if (acc && is_legal(opcode)) m_ex = slot_t'{v: 1'b1, op: opcode, rd: id_rd};
      else m_ex = '0;
      m_illegal = acc && !is_legal(opcode);
      m_mul_left = (m_ex.v && m_ex.op == MUL) ? MUL_LAT - 1 : 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered at posedge+1; compares at the falling edge, returns at posedge+1.
  task automatic step(input logic v, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic fl);
    id_valid  = v;
    opcode    = op;
    id_rd     = rd;
    id_rn     = rn;
    id_rm     = rm;
    ext_flush = fl;
    #4;
    compare_model();
    s_stall = stall_id;
    s_r2l   = id_Reg2Loc;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    id_valid  = 1'b0;
    ext_flush = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ALUSrc", ex_ALUSrc, 0);
    check("rst_ex_ALUOp", ex_ALUOp, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_MemWrite", mem_MemWrite, 0);
    check("rst_mem_MemRead", mem_MemRead, 0);
    check("rst_wb_RegWrite", wb_RegWrite, 0);
    check("rst_wb_MemToReg", wb_MemToReg, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_illegal", illegal, 0);
    check("rst_stall_id", stall_id, 0);
    m_ex = '0;
    m_mem = '0;
    m_wb = '0;
    m_mul_left = 0;
    m_illegal = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 3))
      0: return 5'd2;
      1: return 5'd3;
      2: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic       r_v;
    logic [3:0] r_op;
    logic [4:0] r_rd, r_rn, r_rm;

    do_reset();

    // 1: ADDI, STUR, LDUR, B stream
    step(1, ADDI, 5'd1, 5'd2, 5'd0, 0);
    step(1, STUR, 5'd4, 5'd5, 5'd0, 0);
    step(1, LDUR, 5'd6, 5'd7, 5'd0, 0);
    check("t1_wb_regw_addi", wb_RegWrite, 1);
    check("t1_memw_stur", mem_MemWrite, 1);
    step(1, B, 5'd0, 5'd0, 5'd0, 0);
    check("t1_wb_regw_stur", wb_RegWrite, 0);
    check("t1_memw_ldur", mem_MemWrite, 0);
    check("t1_memr_ldur", mem_MemRead, 1);
    nop(1);
    check("t1_wb_regw_ldur", wb_RegWrite, 1);
    check("t1_wb_m2r_ldur", wb_MemToReg, 1);
    check("t1_wb_rd_ldur", wb_rd, 6);
    nop(1);
    check("t1_wb_regw_b", wb_RegWrite, 0);
    nop(3);

    // 2: load-use on Rn, then XZR exemption
    step(1, LDUR, 5'd3, 5'd1, 5'd0, 0);
    step(1, ADDS, 5'd5, 5'd3, 5'd4, 0);
    check("t2_stall", s_stall, 1);
    check("t2_bubble", ex_valid, 0);
    step(1, ADDS, 5'd5, 5'd3, 5'd4, 0);
    check("t2_stall_once", s_stall, 0);
    check("t2_adds_ex", ex_valid, 1);
    check("t2_adds_rd", ex_rd, 5);
    nop(3);
    step(1, LDUR, 5'd31, 5'd1, 5'd0, 0);
    step(1, ADDS, 5'd5, 5'd31, 5'd4, 0);
    check("t2_xzr_nostall", s_stall, 0);
    check("t2_xzr_ex", ex_valid, 1);
    nop(3);

    // 3: load-use through the Rd/Rt second-source path
    step(1, LDUR, 5'd2, 5'd1, 5'd0, 0);
    step(1, STUR, 5'd2, 5'd7, 5'd9, 0);
    check("t3_stur_stall", s_stall, 1);
    check("t3_stur_r2l", s_r2l, 0);
    step(1, STUR, 5'd2, 5'd7, 5'd9, 0);
    nop(3);
    step(1, LDUR, 5'd2, 5'd1, 5'd0, 0);
    step(1, CBZ, 5'd2, 5'd0, 5'd9, 0);
    check("t3_cbz_stall", s_stall, 1);
    step(1, CBZ, 5'd2, 5'd0, 5'd9, 0);
    nop(3);
    step(1, LDUR, 5'd2, 5'd1, 5'd0, 0);
    step(1, ADDI, 5'd9, 5'd5, 5'd2, 0);
    check("t3_addi_rm_ignored", s_stall, 0);
    nop(3);

    // 4: MUL occupies EX for MUL_LAT cycles, flush ignored while busy
    step(1, MUL, 5'd8, 5'd1, 5'd9, 0);
    step(1, ADDI, 5'd10, 5'd1, 5'd0, 0);
    check("t4_stall1", s_stall, 1);
    check("t4_mem_bubble1", mem_valid, 0);
    step(1, ADDI, 5'd10, 5'd1, 5'd0, 1);
    check("t4_stall2", s_stall, 1);
    check("t4_mem_bubble2", mem_valid, 0);
    check("t4_mul_held", ex_valid, 1);
    step(1, ADDI, 5'd10, 5'd1, 5'd0, 0);
    check("t4_release", s_stall, 0);
    check("t4_mul_mem", mem_valid, 1);
    check("t4_addi_ex", ex_ALUSrc, 2);
    nop(1);
    check("t4_wb_m2r", wb_MemToReg, 2);
    check("t4_wb_regw", wb_RegWrite, 1);
    check("t4_wb_rd", wb_rd, 8);
    nop(3);

    // 5: flush kills ID; illegal opcode
    step(1, ADDI, 5'd4, 5'd1, 5'd0, 1);
    check("t5_flush_nostall", s_stall, 0);
    check("t5_flush_bubble", ex_valid, 0);
    nop(2);
    check("t5_flush_no_regw", wb_RegWrite, 0);
    step(1, 4'd13, 5'd1, 5'd1, 5'd1, 0);
    check("t5_illegal", illegal, 1);
    check("t5_illegal_bubble", ex_valid, 0);
    nop(1);
    check("t5_illegal_pulse", illegal, 0);
    step(1, 4'd13, 5'd1, 5'd1, 5'd1, 1);
    check("t5_flushed_illegal", illegal, 0);
    nop(3);

    // 6: reset during MUL busy
    step(1, MUL, 5'd8, 5'd1, 5'd9, 0);
    do_reset();
    nop(1);
    check("t6_stall_after", s_stall, 0);
    check("t6_ex_empty", ex_valid, 0);
    check("t6_mem_empty", mem_valid, 0);
    nop(2);

    // random traffic; a stalled instruction is presented again
    r_v = 0; r_op = 0; r_rd = 0; r_rn = 0; r_rm = 0;
    s_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!s_stall) begin
        r_v = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) != 0) r_op = 4'($urandom_range(1, 11));
        else r_op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(12, 15)) : 4'd0;
        r_rd = rand_reg();
        r_rn = rand_reg();
        r_rm = rand_reg();
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        s_stall = 1'b0;
      end else begin
        step(r_v, r_op, r_rd, r_rn, r_rm, $urandom_range(0, 9) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
